// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar Wishbone scanner: FSM states,
// channel-index width, register-window layout and the next-enabled-channel search.
package sonar_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } scan_state_e;

  localparam int MAX_CH    = 16;
  localparam int CH_W      = 4;
  localparam int REG_OFS   = 2;
  localparam int CH_STRIDE = 16;
  localparam int TMO_W     = 8;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } ch_pick_t;

  // Lowest enabled channel at or above 'from'; 'from' is one bit wider so 16 means "none left".
  function automatic ch_pick_t next_ch(input logic [MAX_CH-1:0] mask, input logic [CH_W:0] from);
    ch_pick_t pick;
    pick = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        pick.found = 1'b1;
        pick.idx   = CH_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sonar_wb_timeout.sv
// Loadable down-counter bounding a bus transfer; expire_o is high during the
// last permitted cycle (count == 1), so an ack in that same cycle still wins.
module sonar_wb_timeout
  import sonar_pkg::*;
#(
  parameter int CNT_W = TMO_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sonar_wb_scanner.sv
// Wishbone classic read initiator sweeping one register across enabled sonar channels,
// one transfer at a time with a GAP cycle between; optional threshold hits via SONAR_SCAN_THRESH_EN.
module sonar_wb_scanner
  import sonar_pkg::*;
#(
  parameter int          NUM_CH      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [3:0]  reg_sel_i,
  input  logic [15:0] ch_mask_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        rd_valid_o,
  output logic [3:0]  rd_ch_o,
  output logic [15:0] rd_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  err_ch_o
`ifdef SONAR_SCAN_THRESH_EN
  ,
  input  logic [15:0] thresh_i,
  output logic [15:0] hit_o
`endif
);

  localparam logic [15:0] CH_VALID = 16'((33'h1 << NUM_CH) - 33'h1);

  scan_state_e     state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, reg_q, reg_d, rd_ch_q, rd_ch_d, err_ch_q, err_ch_d;
  logic [15:0]     mask_q, mask_d, rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d, err_q, err_d;
  logic [15:0]     scan_mask;
  logic [CH_W:0]   scan_from;
  ch_pick_t        pick;
  logic            tmo_load, tmo_expire;
  logic [31:0]     word_idx;
  logic            unused_dat;

  assign unused_dat = ^wbm_dat_i[31:16];

  // In IDLE search the live mask from 0; in GAP search the latched mask past the current channel.
  always_comb begin
    scan_mask = (state_q == S_IDLE) ? (ch_mask_i & CH_VALID) : mask_q;
    scan_from = (state_q == S_IDLE) ? '0 : ({1'b0, ch_q} + 5'd1);
    pick      = next_ch(scan_mask, scan_from);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = pick.found ? S_REQ : S_DONE;
      S_REQ:   if (wbm_ack_i || tmo_expire) state_d = S_GAP;
      S_GAP:   state_d = pick.found ? S_REQ : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tmo_load = (state_d == S_REQ) && (state_q != S_REQ);

  sonar_wb_timeout #(.CNT_W(TMO_W)) u_timeout (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_ni),
    .load_i     (tmo_load),
    .load_val_i (TMO_W'(TIMEOUT_CYC)),
    .dec_i      (state_q == S_REQ),
    .expire_o   (tmo_expire)
  );

`ifdef SONAR_SCAN_THRESH_EN
  logic [15:0] hit_q, hit_d;
`endif

  always_comb begin
    ch_d       = ch_q;
    reg_d      = reg_q;
    mask_d     = mask_q;
    rd_valid_d = 1'b0;
    rd_ch_d    = rd_ch_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    err_ch_d   = err_ch_q;
`ifdef SONAR_SCAN_THRESH_EN
    hit_d      = hit_q;
`endif
    if ((state_q == S_IDLE) && start_i) begin
      mask_d = ch_mask_i & CH_VALID;
      reg_d  = reg_sel_i;
      err_d  = 1'b0;
`ifdef SONAR_SCAN_THRESH_EN
      hit_d  = '0;
`endif
    end
    if (tmo_load) begin
      ch_d = pick.idx;
    end
    // Ack is checked before expiry so a last-cycle ack is a success.
    if ((state_q == S_REQ) && wbm_ack_i) begin
      rd_valid_d = 1'b1;
      rd_ch_d    = ch_q;
      rd_data_d  = wbm_dat_i[15:0];
`ifdef SONAR_SCAN_THRESH_EN
      if ($signed(wbm_dat_i[15:0]) > $signed(thresh_i)) hit_d[ch_q] = 1'b1;
`endif
    end else if ((state_q == S_REQ) && tmo_expire) begin
      err_d    = 1'b1;
      err_ch_d = ch_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ch_q       <= '0;
      reg_q      <= '0;
      mask_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
`ifdef SONAR_SCAN_THRESH_EN
      hit_q      <= '0;
`endif
    end else begin
      ch_q       <= ch_d;
      reg_q      <= reg_d;
      mask_q     <= mask_d;
      rd_valid_q <= rd_valid_d;
      rd_ch_q    <= rd_ch_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
`ifdef SONAR_SCAN_THRESH_EN
      hit_q      <= hit_d;
`endif
    end
  end

  always_comb begin
    word_idx   = 32'(REG_OFS) + 32'(ch_q) * 32'(CH_STRIDE) + 32'(reg_q);
    wbm_cyc_o  = (state_q == S_REQ);
    wbm_stb_o  = (state_q == S_REQ);
    wbm_we_o   = 1'b0;
    wbm_sel_o  = 4'hF;
    wbm_dat_o  = '0;
    wbm_adr_o  = (state_q == S_REQ) ? (BASE_ADDR + {word_idx[29:0], 2'b00}) : '0;
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);
    rd_valid_o = rd_valid_q;
    rd_ch_o    = rd_ch_q;
    rd_data_o  = rd_data_q;
    err_o      = err_q;
    err_ch_o   = err_ch_q;
`ifdef SONAR_SCAN_THRESH_EN
    hit_o      = hit_q;
`endif
  end

endmodule

// File: tb/tb_sonar_wb_scanner.sv
// Directed bench for sonar_wb_scanner: a Wishbone responder model with programmable
// ack delay, plus address/result scoreboards filled when each scan is launched.
module tb_sonar_wb_scanner;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  reg_sel = '0;
  logic [15:0] ch_mask = '0;
  logic        ack = 1'b0;
  logic [31:0] dat_in = '0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, rd_valid_o, done_o, err_o;
  logic [3:0]  wbm_sel_o, rd_ch_o, err_ch_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [15:0] rd_data_o;
`ifdef SONAR_SCAN_THRESH_EN
  logic [15:0] thresh = '0;
  logic [15:0] hit_o;
`endif

  sonar_wb_scanner dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .start_i   (start),
    .reg_sel_i (reg_sel),
    .ch_mask_i (ch_mask),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (ack),
    .wbm_dat_i (dat_in),
    .busy_o    (busy_o),
    .rd_valid_o(rd_valid_o),
    .rd_ch_o   (rd_ch_o),
    .rd_data_o (rd_data_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_ch_o  (err_ch_o)
`ifdef SONAR_SCAN_THRESH_EN
    ,
    .thresh_i  (thresh),
    .hit_o     (hit_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_adr_q[$];
  logic [19:0] exp_rd_q[$];
  logic [31:0] resp_dat[16];
  int  ack_delay = 1;
  bit  resp_en = 1'b1;
  int  wait_cnt = 0;
  int  n_xfer = 0, n_done = 0, n_rdv = 0, cur_len = 0, last_len = 0, cyc_no = 0, last_fall = 0;
  bit  last_fall_vld = 1'b0, gap_chk_en = 1'b0, cyc_prev = 1'b0;
  logic [31:0] rise_adr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_adr(input int ch, input int rs);
    return BASE + 32'(4 * (2 + 16 * ch + rs));
  endfunction

  function automatic int adr2ch(input logic [31:0] adr);
    int w;
    w = int'((adr - BASE) >> 2);
    return ((w - 2) >> 4) & 15;
  endfunction

  // Responder: raises ack in the ack_delay-th cycle of a request.
  always @(negedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !ack) begin
      wait_cnt++;
      if (resp_en && (wait_cnt == ack_delay)) begin
        ack    = 1'b1;
        dat_in = resp_dat[adr2ch(wbm_adr_o)];
      end
    end else begin
      ack      = 1'b0;
      wait_cnt = 0;
      dat_in   = '0;
    end
  end

  always @(negedge clk) begin
    cyc_no++;
    if (done_o) n_done++;
    if (wbm_cyc_o) begin
      if (!cyc_prev) begin
        n_xfer++;
        cur_len  = 0;
        rise_adr = wbm_adr_o;
        if (gap_chk_en && last_fall_vld) chk("gap_cycles", 32'(cyc_no - last_fall), 1);
        chk("stb_with_cyc", wbm_stb_o, 1);
        chk("sel_const", wbm_sel_o, 4'hF);
        chk("we_low", wbm_we_o, 0);
        chk("adr_expected", exp_adr_q.size() != 0, 1);
        if (exp_adr_q.size() != 0) chk("adr", wbm_adr_o, exp_adr_q.pop_front());
      end else begin
        chk("adr_stable", wbm_adr_o, rise_adr);
      end
      cur_len++;
    end else if (cyc_prev) begin
      last_len      = cur_len;
      last_fall     = cyc_no;
      last_fall_vld = 1'b1;
    end
    if (rd_valid_o) begin
      n_rdv++;
      chk("rd_expected", exp_rd_q.size() != 0, 1);
      if (exp_rd_q.size() != 0) chk("rd_ch_data", {12'h0, rd_ch_o, rd_data_o}, 32'(exp_rd_q.pop_front()));
    end
    cyc_prev = wbm_cyc_o;
  end

  task automatic clr();
    @(posedge clk); #1;
    n_xfer = 0; n_done = 0; n_rdv = 0; last_fall_vld = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] m, input logic [3:0] r);
    @(posedge clk); #1;
    ch_mask = m; reg_sel = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      n++;
    end
    chk(tag, seen, 1);
  endtask

  task automatic settle_check(input string tag, input int xfer, input int rdv);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy_o, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_xfers"}, n_xfer, xfer);
    chk({tag, "_rdv_cnt"}, n_rdv, rdv);
    chk({tag, "_adr_q_empty"}, exp_adr_q.size(), 0);
    chk({tag, "_rd_q_empty"}, exp_rd_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) resp_dat[i] = 32'hDEAD_0000 | (i * 32'h0101);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_sel", wbm_sel_o, 4'hF);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdv", rd_valid_o, 0);
    chk("rst_err", {err_o, err_ch_o}, 0);
    chk("rst_rd", {rd_ch_o, rd_data_o}, 0);
    rst_n = 1'b1;

    // Single channel, ack after 2 cycles
    clr();
    resp_dat[0] = 32'hFFFF_8001; ack_delay = 2; resp_en = 1'b1;
    exp_adr_q.push_back(32'h3000_0008);
    exp_rd_q.push_back({4'd0, 16'h8001});
    do_start(16'h0001, 4'd0);
    wait_done("s1_done");
    settle_check("s1", 1, 1);
    chk("s1_cyc_len", last_len, 2);
    chk("s1_err", err_o, 0);

    // Sparse mask, skipped channels, start while busy ignored
    clr();
    resp_dat[0] = 32'hDEAD_0000;
    ack_delay = 1; gap_chk_en = 1'b1;
    foreach (exp_adr_q[i]) exp_adr_q.delete(i);
    for (int c = 0; c < 16; c += 5) begin
      exp_adr_q.push_back(exp_adr(c, 15));
      exp_rd_q.push_back({4'(c), 16'(c * 16'h0101)});
    end
    do_start(16'h8421, 4'd15);
    repeat (3) @(posedge clk);
    #1; ch_mask = 16'h0002; reg_sel = 4'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("s2_done");
    settle_check("s2", 4, 4);
    gap_chk_en = 1'b0;

    // No ack: timeout
    clr();
    resp_en = 1'b0;
    exp_adr_q.push_back(exp_adr(2, 3));
    do_start(16'h0004, 4'd3);
    wait_done("s3_done");
    settle_check("s3", 1, 0);
    chk("s3_cyc_len", last_len, 15);
    chk("s3_err", err_o, 1);
    chk("s3_err_ch", err_ch_o, 2);
    resp_en = 1'b1;

    // Empty mask: straight to DONE, clears sticky err
    clr();
    do_start(16'h0000, 4'd0);
    chk("s4_done_now", done_o, 1);
    chk("s4_busy_now", busy_o, 1);
    chk("s4_err_cleared", err_o, 0);
    chk("s4_no_cyc", wbm_cyc_o, 0);
    @(posedge clk); #1;
    chk("s4_done_gone", done_o, 0);
    chk("s4_idle", busy_o, 0);
    repeat (3) @(posedge clk);
    chk("s4_xfers", n_xfer, 0);
    chk("s4_done_cnt", n_done, 1);

    // Ack on last permitted cycle; address example ch 3 reg 5
    clr();
    ack_delay = 15; resp_dat[3] = 32'h0000_7FFF;
    exp_adr_q.push_back(32'h3000_00DC);
    exp_rd_q.push_back({4'd3, 16'h7FFF});
    do_start(16'h0008, 4'd5);
    wait_done("s5_done");
    settle_check("s5", 1, 1);
    chk("s5_cyc_len", last_len, 15);
    chk("s5_err", err_o, 0);

    // Reset mid-transfer, then a normal scan
    clr();
    resp_en = 1'b0;
    exp_adr_q.push_back(exp_adr(1, 0));
    do_start(16'h0002, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("s6_cyc_before", wbm_cyc_o, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_cyc_in_rst", wbm_cyc_o, 0);
    chk("s6_stb_in_rst", wbm_stb_o, 0);
    chk("s6_busy_in_rst", busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s6_idle_after", busy_o, 0);
    clr();
    resp_en = 1'b1; ack_delay = 3; resp_dat[1] = 32'h1234_ABCD;
    exp_adr_q.push_back(exp_adr(1, 0));
    exp_rd_q.push_back({4'd1, 16'hABCD});
    do_start(16'h0002, 4'd0);
    wait_done("s6_done");
    settle_check("s6", 1, 1);
    chk("s6_cyc_len", last_len, 3);

`ifdef SONAR_SCAN_THRESH_EN
    // Signed threshold compare
    clr();
    ack_delay = 1; thresh = 16'sd100;
    resp_dat[1] = 32'd101; resp_dat[2] = 32'h0000_FFFB;
    exp_adr_q.push_back(exp_adr(1, 0)); exp_rd_q.push_back({4'd1, 16'd101});
    exp_adr_q.push_back(exp_adr(2, 0)); exp_rd_q.push_back({4'd2, 16'hFFFB});
    do_start(16'h0006, 4'd0);
    wait_done("s7_done");
    settle_check("s7", 2, 2);
    chk("s7_hit", hit_o, 16'h0002);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
